// File: rtl/dpi_stream_regex_ctx.sv
// Per-stream context manager for one regex DFA engine: saves and restores DFA state per stream,
// registers the DFA interface, and keeps saturating global and per-stream match counters.
module dpi_stream_regex_ctx #(
  parameter int STATE_W = 11,
  parameter int SID_W   = 6,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_state,
  input  logic               new_stream_id,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               enable,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic               eop,
  input  logic               cnt_clr,
  input  logic [SID_W-1:0]   rd_sid,
  output logic [COUNT_W-1:0] rd_count,
  output logic [COUNT_W-1:0] count,
  output logic               fired,
  output logic [7:0]         dfa_char,
  output logic               dfa_char_vld,
  output logic [STATE_W-1:0] dfa_state_in,
  output logic               dfa_state_in_vld,
  input  logic [STATE_W-1:0] dfa_state_out,
  input  logic               dfa_accept
);

  localparam int NUM_STREAMS = 2 ** SID_W;
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  logic [STATE_W-1:0] state_mem [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] valid;
  logic [COUNT_W-1:0] cnt [NUM_STREAMS];

  logic [SID_W-1:0]   cur_sid;
  logic [STATE_W-1:0] st_r;
  logic               acc_r;
  logic [STATE_W-1:0] stage_val;
  logic               stage_vld;

  logic               save_en;
  logic               hit;
  logic [STATE_W-1:0] restore_val;
  logic               fired_nxt;

  assign save_en = eop & enable;
  assign hit     = save_en & (fired | acc_r);

  // A save to the slot being loaded in the same cycle is forwarded from st_r.
  always_comb begin
    restore_val = '0;
    if (!new_stream_id) begin
      if (save_en && (stream_id == cur_sid)) begin
        restore_val = st_r;
      end else if (valid[stream_id]) begin
        restore_val = state_mem[stream_id];
      end
    end
  end

  // eop ends the packet's match window; a load with a coincident accept still flags the new packet.
  always_comb begin
    fired_nxt = eop ? 1'b0 : fired;
    if (load_state) fired_nxt = 1'b0;
    if (acc_r && (load_state || !eop)) fired_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dfa_char         <= '0;
      dfa_char_vld     <= 1'b0;
      st_r             <= '0;
      acc_r            <= 1'b0;
      cur_sid          <= '0;
      stage_val        <= '0;
      stage_vld        <= 1'b0;
      dfa_state_in     <= '0;
      dfa_state_in_vld <= 1'b0;
      fired            <= 1'b0;
    end else begin
      dfa_char         <= char_in;
      dfa_char_vld     <= char_in_vld;
      st_r             <= dfa_state_out;
      acc_r            <= dfa_accept;
      stage_vld        <= load_state;
      dfa_state_in_vld <= stage_vld;
      fired            <= fired_nxt;
      if (load_state) begin
        cur_sid   <= stream_id;
        stage_val <= restore_val;
      end
      if (stage_vld) dfa_state_in <= stage_val;
    end
  end

  // State memory is left unreset; the valid bits decide whether its contents are used.
  always_ff @(posedge clk) begin
    if (save_en) state_mem[cur_sid] <= st_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      valid <= '0;
    end else if (save_en) begin
      valid[cur_sid] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      count <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) cnt[i] <= '0;
    end else if (hit) begin
      if (count != CNT_MAX) count <= count + COUNT_W'(1);
      if (cnt[cur_sid] != CNT_MAX) cnt[cur_sid] <= cnt[cur_sid] + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_count <= '0;
    else        rd_count <= cnt[rd_sid];
  end

endmodule

// File: tb/tb_dpi_stream_regex_ctx.sv
// Directed bench for dpi_stream_regex_ctx: a default instance plus a COUNT_W=4 instance
// sharing stimulus so saturation can be observed in a short run.
module tb_dpi_stream_regex_ctx;
  localparam int STATE_W = 11;
  localparam int SID_W   = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic load_state, new_stream_id, enable, char_in_vld, eop, cnt_clr, dfa_accept;
  logic [SID_W-1:0] stream_id, rd_sid;
  logic [7:0] char_in;
  logic [STATE_W-1:0] dfa_state_out;

  logic [15:0] rd_count, count;
  logic fired, dfa_char_vld, dfa_state_in_vld;
  logic [7:0] dfa_char;
  logic [STATE_W-1:0] dfa_state_in;

  logic [3:0] rd_count4, count4;
  logic fired4, dfa_char_vld4, dfa_state_in_vld4;
  logic [7:0] dfa_char4;
  logic [STATE_W-1:0] dfa_state_in4;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dpi_stream_regex_ctx dut (
    .clk(clk), .rst_n(rst_n), .load_state(load_state), .new_stream_id(new_stream_id),
    .stream_id(stream_id), .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld),
    .eop(eop), .cnt_clr(cnt_clr), .rd_sid(rd_sid), .rd_count(rd_count), .count(count),
    .fired(fired), .dfa_char(dfa_char), .dfa_char_vld(dfa_char_vld),
    .dfa_state_in(dfa_state_in), .dfa_state_in_vld(dfa_state_in_vld),
    .dfa_state_out(dfa_state_out), .dfa_accept(dfa_accept)
  );

  dpi_stream_regex_ctx #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_state(load_state), .new_stream_id(new_stream_id),
    .stream_id(stream_id), .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld),
    .eop(eop), .cnt_clr(cnt_clr), .rd_sid(rd_sid), .rd_count(rd_count4), .count(count4),
    .fired(fired4), .dfa_char(dfa_char4), .dfa_char_vld(dfa_char_vld4),
    .dfa_state_in(dfa_state_in4), .dfa_state_in_vld(dfa_state_in_vld4),
    .dfa_state_out(dfa_state_out), .dfa_accept(dfa_accept)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_state = 0; new_stream_id = 0; stream_id = '0; enable = 0; char_in = '0;
    char_in_vld = 0; eop = 0; cnt_clr = 0; dfa_accept = 0;
  endtask

  // Pulses load_state for one cycle, then waits so dfa_state_in shows the restore value.
  task automatic load_and_wait(input logic [SID_W-1:0] sid, input logic nsid);
    load_state = 1; stream_id = sid; new_stream_id = nsid;
    step();
    load_state = 0; new_stream_id = 0;
    step();
  endtask

  // One packet whose accept reaches acc_r exactly in the eop cycle.
  task automatic match_packet(input logic en);
    dfa_accept = 1;
    step();
    dfa_accept = 0; eop = 1; enable = en;
    step();
    eop = 0; enable = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_sid = '0; dfa_state_out = '0; rst_n = 0;
    step(); step();
    rst_n = 1;
    n_total++; if (count !== 16'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_total++; if (fired !== 1'b0) $display("FAIL reset_fired got %0b want 0", fired); else n_pass++;
    n_total++; if (rd_count !== 16'd0) $display("FAIL reset_rd_count got %0d want 0", rd_count); else n_pass++;
    n_total++; if ({dfa_state_in_vld, dfa_char_vld} !== 2'b00)
      $display("FAIL reset_vld got %b want 00", {dfa_state_in_vld, dfa_char_vld}); else n_pass++;
    load_and_wait(6'd5, 1'b0);
    n_total++; if (dfa_state_in !== 11'h000 || dfa_state_in_vld !== 1'b1)
      $display("FAIL load_invalid_sid5 got %h/%b want 000/1", dfa_state_in, dfa_state_in_vld); else n_pass++;
    n_total++; if (count !== 16'd0 || fired !== 1'b0)
      $display("FAIL after_load_count_fired got %0d/%0b want 0/0", count, fired); else n_pass++;
  endtask

  task automatic test_char_pipe();
    char_in = 8'h5A; char_in_vld = 1;
    step();
    char_in = 8'h00; char_in_vld = 0;
    n_total++; if (dfa_char !== 8'h5A || dfa_char_vld !== 1'b1)
      $display("FAIL char_pipe got %h/%b want 5a/1", dfa_char, dfa_char_vld); else n_pass++;
    step();
    n_total++; if (dfa_char_vld !== 1'b0) $display("FAIL char_vld_drop got %b want 0", dfa_char_vld); else n_pass++;
  endtask

  task automatic test_save_restore();
    dfa_state_out = 11'h2A3;
    load_state = 1; stream_id = 6'd3; new_stream_id = 1;
    step();
    load_state = 0; new_stream_id = 0;
    eop = 1; enable = 1;
    step();
    eop = 0; enable = 0;
    load_and_wait(6'd3, 1'b0);
    n_total++; if (dfa_state_in !== 11'h2A3 || dfa_state_in_vld !== 1'b1)
      $display("FAIL restore_sid3 got %h/%b want 2a3/1", dfa_state_in, dfa_state_in_vld); else n_pass++;
    step();
    n_total++; if (dfa_state_in_vld !== 1'b0)
      $display("FAIL state_in_vld_pulse got %b want 0", dfa_state_in_vld); else n_pass++;
  endtask

  task automatic test_match_count();
    rd_sid = 6'd3;
    match_packet(1'b1);
    n_total++; if (count !== 16'd1 || fired !== 1'b0)
      $display("FAIL eop_match_count got %0d/%0b want 1/0", count, fired); else n_pass++;
    step();
    n_total++; if (rd_count !== 16'd1) $display("FAIL rd_count_sid3 got %0d want 1", rd_count); else n_pass++;
    match_packet(1'b0);
    n_total++; if (count !== 16'd1 || fired !== 1'b0)
      $display("FAIL disabled_eop got %0d/%0b want 1/0", count, fired); else n_pass++;
    step();
    n_total++; if (rd_count !== 16'd1) $display("FAIL rd_count_disabled got %0d want 1", rd_count); else n_pass++;
  endtask

  task automatic test_fired();
    dfa_accept = 1;
    step();
    dfa_accept = 0;
    step();
    n_total++; if (fired !== 1'b1) $display("FAIL fired_set got %b want 1", fired); else n_pass++;
    load_state = 1; stream_id = 6'd2; new_stream_id = 1;
    step();
    load_state = 0; new_stream_id = 0;
    n_total++; if (fired !== 1'b0) $display("FAIL fired_load_clear got %b want 0", fired); else n_pass++;
    dfa_accept = 1;
    step();
    dfa_accept = 0; load_state = 1; stream_id = 6'd2;
    step();
    load_state = 0;
    n_total++; if (fired !== 1'b1) $display("FAIL fired_load_and_acc got %b want 1", fired); else n_pass++;
    eop = 1; enable = 0;
    step();
    eop = 0;
    n_total++; if (fired !== 1'b0) $display("FAIL fired_eop_disabled got %b want 0", fired); else n_pass++;
  endtask

  task automatic test_forwarding();
    dfa_state_out = 11'h011;
    load_state = 1; stream_id = 6'd7; new_stream_id = 1;
    step();
    eop = 1; enable = 1; load_state = 1; stream_id = 6'd7; new_stream_id = 0;
    step();
    eop = 0; enable = 0; load_state = 0;
    step();
    n_total++; if (dfa_state_in !== 11'h011) $display("FAIL fwd_sid7 got %h want 011", dfa_state_in); else n_pass++;
    eop = 1; enable = 1; load_state = 1; stream_id = 6'd7; new_stream_id = 1;
    step();
    eop = 0; enable = 0; load_state = 0; new_stream_id = 0;
    step();
    n_total++; if (dfa_state_in !== 11'h000) $display("FAIL fwd_new_sid got %h want 000", dfa_state_in); else n_pass++;
    load_and_wait(6'd7, 1'b0);
    n_total++; if (dfa_state_in !== 11'h011) $display("FAIL mem_sid7 got %h want 011", dfa_state_in); else n_pass++;
    dfa_state_out = 11'h7FF;
    step();
    eop = 1; enable = 1; load_state = 1; stream_id = 6'd9;
    step();
    eop = 0; enable = 0; load_state = 0;
    step();
    n_total++; if (dfa_state_in !== 11'h000) $display("FAIL load_sid9_other got %h want 000", dfa_state_in); else n_pass++;
    load_and_wait(6'd7, 1'b0);
    n_total++; if (dfa_state_in !== 11'h7FF) $display("FAIL save_old_sid7 got %h want 7ff", dfa_state_in); else n_pass++;
  endtask

  task automatic test_saturation();
    rst_n = 0;
    step();
    rst_n = 1;
    load_and_wait(6'd3, 1'b0);
    n_total++; if (dfa_state_in !== 11'h000) $display("FAIL post_reset_sid3 got %h want 000", dfa_state_in); else n_pass++;
    rd_sid = 6'd1;
    load_state = 1; stream_id = 6'd1; new_stream_id = 1;
    step();
    load_state = 0; new_stream_id = 0;
    for (int i = 0; i < 20; i++) match_packet(1'b1);
    step();
    n_total++; if (count !== 16'd20 || rd_count !== 16'd20)
      $display("FAIL wide_count_20 got %0d/%0d want 20/20", count, rd_count); else n_pass++;
    n_total++; if (count4 !== 4'd15 || rd_count4 !== 4'd15)
      $display("FAIL sat_count4 got %0d/%0d want 15/15", count4, rd_count4); else n_pass++;
    match_packet(1'b1);
    step(); step();
    n_total++; if (count4 !== 4'd15 || rd_count4 !== 4'd15 || count !== 16'd21)
      $display("FAIL sat_held got %0d/%0d/%0d want 15/15/21", count4, rd_count4, count); else n_pass++;
  endtask

  task automatic test_cnt_clr();
    dfa_state_out = 11'h155; dfa_accept = 1;
    step();
    dfa_accept = 0; eop = 1; enable = 1; cnt_clr = 1;
    step();
    eop = 0; enable = 0; cnt_clr = 0;
    step();
    n_total++; if (count !== 16'd0 || count4 !== 4'd0)
      $display("FAIL clr_count got %0d/%0d want 0/0", count, count4); else n_pass++;
    n_total++; if (rd_count !== 16'd0 || rd_count4 !== 4'd0)
      $display("FAIL clr_rd_count got %0d/%0d want 0/0", rd_count, rd_count4); else n_pass++;
    load_and_wait(6'd1, 1'b0);
    n_total++; if (dfa_state_in !== 11'h000) $display("FAIL clr_valid_sid1 got %h want 000", dfa_state_in); else n_pass++;
    match_packet(1'b1);
    step();
    n_total++; if (count !== 16'd1 || rd_count !== 16'd1)
      $display("FAIL count_after_clr got %0d/%0d want 1/1", count, rd_count); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_char_pipe();
    test_save_restore();
    test_match_count();
    test_fired();
    test_forwarding();
    test_saturation();
    test_cnt_clr();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
